// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field widths, operand types and unpack helper
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = 1 + MAN_W + 3;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp_eff;
    logic [MAN_W:0]   sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp32_unpack_t;

  typedef enum logic [1:0] {
    FP_NORM = 2'b00,
    FP_INF  = 2'b01,
    FP_NAN  = 2'b10
  } fp_special_e;

  // Denormals (and zero) take exponent 1 with no hidden bit.
  function automatic fp32_unpack_t fp32_unpack(input fp32_t x);
    fp32_unpack_t u;
    u.sign    = x.sign;
    u.exp_eff = (x.exp == '0) ? EXP_W'(1) : x.exp;
    u.sig     = {x.exp != '0, x.frac};
    u.is_zero = (x.exp == '0) && (x.frac == '0);
    u.is_inf  = (x.exp == '1) && (x.frac == '0);
    u.is_nan  = (x.exp == '1) && (x.frac != '0);
    return u;
  endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// rtl/fp_rshift_sticky.sv - right shift that collapses shifted-out bits into bit 0
module fp_rshift_sticky #(
  parameter int W = 27
) (
  input  logic [W-1:0] din,
  input  logic [7:0]   shamt,
  output logic [W-1:0] dout
);

  localparam logic [7:0] W_LIM = 8'(W);

  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         sticky;

  // Shift, then OR every dropped bit (and the original LSB) into the new LSB.
  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    dout      = '0;
    if (shamt >= W_LIM) begin
      dout = {{(W-1){1'b0}}, |din};
    end else begin
      shifted   = din >> shamt;
      lost_mask = ~({W{1'b1}} << shamt);
      sticky    = |(din & lost_mask) | din[0];
      dout      = {shifted[W-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fp32_exp_align_stage.sv
// rtl/fp32_exp_align_stage.sv - FP32 adder alignment stage: order, shift, register
module fp32_exp_align_stage
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic             i_sub,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_swap,
  output logic [EXP_W-1:0] o_exp_large,
  output logic [EXP_W-1:0] o_exp_small,
  output logic [SIG_W-1:0] o_sig_large,
  output logic [SIG_W-1:0] o_sig_small,
  output logic             o_sign_large,
  output logic             o_eff_sub,
  output logic [1:0]       o_special
);

  fp32_t        b_adj;
  fp32_unpack_t ua;
  fp32_unpack_t ub;
  logic         swap;
  logic         load;
  logic [EXP_W-1:0] exp_large;
  logic [EXP_W-1:0] exp_small;
  logic [MAN_W:0]   sig_large;
  logic [MAN_W:0]   sig_small;
  logic             small_zero;
  logic             sign_large;
  logic [EXP_W-1:0] diff;
  logic [SIG_W-1:0] sig_small_ext;
  logic [SIG_W-1:0] sig_small_sh;
  logic             eff_sub;
  fp_special_e      special;

  assign o_ready = !o_valid || i_ready;
  assign load    = i_valid && o_ready;

  // Subtraction is folded in by flipping B's sign before anything else looks at it.
  assign b_adj = {i_b[31] ^ i_sub, i_b[30:0]};
  assign ua    = fp32_unpack(i_a);
  assign ub    = fp32_unpack(b_adj);

  // Order by magnitude; an exact tie keeps A as the larger operand.
  always_comb begin
    swap       = {ub.exp_eff, ub.sig} > {ua.exp_eff, ua.sig};
    exp_large  = swap ? ub.exp_eff : ua.exp_eff;
    exp_small  = swap ? ua.exp_eff : ub.exp_eff;
    sig_large  = swap ? ub.sig     : ua.sig;
    sig_small  = swap ? ua.sig     : ub.sig;
    small_zero = swap ? ua.is_zero : ub.is_zero;
    sign_large = swap ? ub.sign    : ua.sign;
    diff       = exp_large - exp_small;
    sig_small_ext = small_zero ? '0 : {sig_small, 3'b000};
    eff_sub    = ua.sign ^ ub.sign;
  end

  fp_rshift_sticky #(.W(SIG_W)) u_rshift (
    .din   (sig_small_ext),
    .shamt (diff),
    .dout  (sig_small_sh)
  );

  // Special-result classification on the unswapped operands.
  always_comb begin
    special = FP_NORM;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && eff_sub))
      special = FP_NAN;
    else if (ua.is_inf || ub.is_inf)
      special = FP_INF;
  end

  // Valid flag: flush kills, load sets, consumption clears, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_valid <= 1'b0;
    else if (i_flush)
      o_valid <= 1'b0;
    else if (load)
      o_valid <= 1'b1;
    else if (i_ready)
      o_valid <= 1'b0;
  end

  // Result register; only a load changes it, so it is frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_swap       <= 1'b0;
      o_exp_large  <= '0;
      o_exp_small  <= '0;
      o_sig_large  <= '0;
      o_sig_small  <= '0;
      o_sign_large <= 1'b0;
      o_eff_sub    <= 1'b0;
      o_special    <= 2'b00;
    end else if (load) begin
      o_swap       <= swap;
      o_exp_large  <= exp_large;
      o_exp_small  <= exp_small;
      o_sig_large  <= {sig_large, 3'b000};
      o_sig_small  <= sig_small_sh;
      o_sign_large <= sign_large;
      o_eff_sub    <= eff_sub;
      o_special    <= special;
    end
  end

endmodule

// File: tb/tb_fp32_exp_align_stage.sv
// tb/tb_fp32_exp_align_stage.sv - self-checking bench for fp32_exp_align_stage
module tb_fp32_exp_align_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_sub = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_swap;
  logic [7:0]  o_exp_large;
  logic [7:0]  o_exp_small;
  logic [26:0] o_sig_large;
  logic [26:0] o_sig_small;
  logic        o_sign_large;
  logic        o_eff_sub;
  logic [1:0]  o_special;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp32_exp_align_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_swap(o_swap),
    .o_exp_large(o_exp_large), .o_exp_small(o_exp_small),
    .o_sig_large(o_sig_large), .o_sig_small(o_sig_small),
    .o_sign_large(o_sign_large), .o_eff_sub(o_eff_sub), .o_special(o_special)
  );

  function automatic logic [74:0] got_vec();
    return {o_swap, o_exp_large, o_exp_small, o_sig_large, o_sig_small,
            o_sign_large, o_eff_sub, o_special};
  endfunction

  // Reference: order by true magnitude of the raw bits, align with plain arithmetic.
  function automatic logic [74:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bm, l, s;
    logic        sw, esub, nan, inf;
    int          el, es, d;
    longint      vl, vs, r, lost;
    logic [1:0]  sp;
    bm   = {b[31] ^ sub, b[30:0]};
    sw   = bm[30:0] > a[30:0];
    l    = sw ? bm : a;
    s    = sw ? a : bm;
    el   = (l[30:23] == 8'd0) ? 1 : int'(l[30:23]);
    es   = (s[30:23] == 8'd0) ? 1 : int'(s[30:23]);
    vl   = ((l[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + longint'(l[22:0]);
    vs   = ((s[30:23] != 8'd0) ? 64'd8388608 : 64'd0) + longint'(s[22:0]);
    vl   = vl * 8;
    vs   = vs * 8;
    d    = el - es;
    if (d >= 27) begin
      r = (vs != 0) ? 1 : 0;
    end else begin
      r    = vs / (64'd1 << d);
      lost = vs - r * (64'd1 << d);
      if (lost != 0) r = r | 1;
    end
    esub = a[31] != bm[31];
    nan  = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
           (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && esub);
    inf  = (a[30:0] == 31'h7F800000) || (b[30:0] == 31'h7F800000);
    sp   = nan ? 2'b10 : (inf ? 2'b01 : 2'b00);
    return {sw, 8'(el), 8'(es), 27'(vl), 27'(r), l[31], esub, sp};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b want=0", o_valid);
    end
    total++;
    if (got_vec() !== 75'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", got_vec());
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%0b want=1", o_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'h3F800000, 32'h3F800001, 32'h40400000, 32'h7F800000, 32'h7F800000};
    logic [31:0] tb [5] = '{32'h40000000, 32'h50000000, 32'h40400000, 32'h7F800000, 32'h3F800000};
    logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [74:0] want [5];
    logic [74:0] w;
    want[0] = {1'b1, 8'h80, 8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 2'b00};
    want[1] = {1'b1, 8'hA0, 8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 2'b00};
    want[2] = {1'b0, 8'h80, 8'h80, 27'h6000000, 27'h6000000, 1'b0, 1'b1, 2'b00};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_a = ta[i]; i_b = tb[i]; i_sub = ts[i]; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      total++;
      if (o_valid !== 1'b1) begin
        bad++; $display("FAIL dir%0d_valid got=%0b want=1", i, o_valid);
      end
      w = model(ta[i], tb[i], ts[i]);
      total++;
      if (got_vec() !== w) begin
        bad++; $display("FAIL dir%0d_model got=%h want=%h", i, got_vec(), w);
      end
      if (i < 3) begin
        total++;
        if (got_vec() !== want[i]) begin
          bad++; $display("FAIL dir%0d_const got=%h want=%h", i, got_vec(), want[i]);
        end
      end else begin
        total++;
        if (o_special !== ((i == 3) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL dir%0d_special got=%b want=%b", i, o_special, (i == 3) ? 2'b10 : 2'b01);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [3] = '{32'h3F800000, 32'hC1200000, 32'h00000005};
    logic [31:0] pb [3] = '{32'h3F000000, 32'h41A00000, 32'h00800000};
    logic        ps [3] = '{1'b0, 1'b1, 1'b0};
    logic [74:0] q [$];
    int idx = 0;
    int rcv = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      i_ready = (c >= 1 && c <= 4) ? 1'b0 : 1'b1;
      i_valid = (idx < 3);
      if (idx < 3) begin
        i_a = pa[idx]; i_b = pb[idx]; i_sub = ps[idx];
      end
      #1;
      if (!i_ready) begin
        total++;
        if (o_ready !== 1'b0) begin
          bad++; $display("FAIL bp_ready c=%0d got=%0b want=0", c, o_ready);
        end
      end
      if (o_valid) begin
        total++;
        if (q.size() == 0 || got_vec() !== q[0]) begin
          bad++; $display("FAIL bp_data c=%0d got=%h want=%h", c, got_vec(), (q.size() != 0) ? q[0] : 75'd0);
        end
        if (i_ready && q.size() != 0) begin
          void'(q.pop_front());
          rcv++;
        end
      end
      if (i_valid && o_ready) begin
        q.push_back(model(i_a, i_b, i_sub));
        idx++;
      end
    end
    i_valid = 1'b0;
    total++;
    if (rcv !== 3 || q.size() !== 0) begin
      bad++; $display("FAIL bp_count got=%0d left=%0d want=3 left=0", rcv, q.size());
    end
  endtask

  task automatic test_random();
    logic [74:0] q [$];
    logic [31:0] a, b;
    int sel;
    int rcv = 0;
    int sent = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; sel = $urandom_range(0, 7);
      case (sel)
        0: b[30:23] = a[30:23] + 8'($urandom_range(0, 30));
        1: b[30:0]  = a[30:0];
        2: a[30:23] = 8'h00;
        3: b[30:23] = 8'hFF;
        4: begin a[30:23] = 8'hFF; a[22:0] = 23'd0; end
        5: a[30:23] = b[30:23] - 8'($urandom_range(0, 3));
        default: ;
      endcase
      i_a = a; i_b = b; i_sub = 1'($urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (o_valid && i_ready) begin
        total++;
        if (q.size() == 0 || got_vec() !== q[0]) begin
          bad++; $display("FAIL rnd c=%0d got=%h want=%h", c, got_vec(), (q.size() != 0) ? q[0] : 75'd0);
        end
        if (q.size() != 0) void'(q.pop_front());
        rcv++;
      end
      if (i_valid && o_ready) begin
        q.push_back(model(i_a, i_b, i_sub));
        sent++;
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    if (o_valid) begin
      if (q.size() != 0) void'(q.pop_front());
      rcv++;
    end
    total++;
    if (rcv !== sent || q.size() !== 0) begin
      bad++; $display("FAIL rnd_count got=%0d want=%0d", rcv, sent);
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    i_a = 32'h40400000; i_b = 32'h3F800000; i_sub = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    total++;
    if (o_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre_valid got=%0b want=1", o_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b0 || got_vec() !== 75'd0) begin
      bad++; $display("FAIL rst_async got=%0b/%h want=0/0", o_valid, got_vec());
    end
    @(negedge clk);
    rst = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    i_a = 32'h3F800000; i_b = 32'h40000000; i_valid = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid got=%0b want=0", o_valid);
    end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL flush_later got=%0b want=0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
